// File: rtl/t05_pc_sequencer_pkg.sv
// t05_ctrl_pkg: shared types and constants for the t05 PC sequencer.
//   state_t        FSM state encoding, as plain localparam constants
//   OP_*           RV32 major opcodes (instr[6:0]) that the sequencer understands
//   instr_class_t  coarse instruction class produced by t05_opcode_classifier
package t05_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_HALT   = 3'd5;
    localparam state_t ST_FAULT  = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/t05_pc_sequencer_if.sv
// t05_pc_sequencer_if: memory request/acknowledge handshake.
//   mem_req    request, held until mem_ack
//   mem_sel    0 = instruction fetch, 1 = data access
//   mem_we     data write (stores only)
//   mem_ack    memory completes the current request
//   mem_rdata  read data (instruction on fetch)
// master = sequencer side, slave = memory side.
interface t05_pc_sequencer_if;
    logic        mem_req;
    logic        mem_sel;
    logic        mem_we;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_sel, mem_we, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_sel, mem_we, output mem_ack, mem_rdata);
endinterface

// File: rtl/t05_opcode_classifier.sv
// t05_opcode_classifier: combinational opcode -> instruction class decode.
//   opcode  in   7  instr[6:0]
//   cls     out  instr_class_t; CLS_ILLEGAL for any opcode not listed
module t05_opcode_classifier
    import t05_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t cls
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: cls = CLS_ALU;
            OP_LOAD:                           cls = CLS_LOAD;
            OP_STORE:                          cls = CLS_STORE;
            OP_BRANCH:                         cls = CLS_BRANCH;
            OP_JAL:                            cls = CLS_JAL;
            OP_JALR:                           cls = CLS_JALR;
            OP_SYSTEM:                         cls = CLS_SYSTEM;
            default:                           cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/t05_pc_sequencer.sv
// t05_pc_sequencer: multi-cycle control FSM for the t05 PC and memory port.
// Fetches an instruction, classifies it, runs the data access for loads/stores,
// then issues exactly one PC command in WB.
// Ports:
//   clk, clr       clock (rising) / async active-high reset
//   run            level; 0 stops at the next instruction boundary
//   branch_taken   ALU compare result, sampled in WB
//   mem            t05_pc_sequencer_if.master (req/sel/we/ack/rdata)
//   instr          latched instruction register
//   reg_we         register-file write strobe (WB)
//   pc_inc/pc_load/pc_branch/pc_disable   PC commands
//   halted, fault  sticky terminal flags, cleared only by clr
// Build option: define CTRL_TIMEOUT_EN to fault when FETCH/MEM waits
// TIMEOUT_CYCLES cycles without mem_ack.
module t05_pc_sequencer
    import t05_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      run,
    input  logic                      branch_taken,
    t05_pc_sequencer_if.master        mem,
    output logic [31:0]               instr,
    output logic                      reg_we,
    output logic                      pc_inc,
    output logic                      pc_load,
    output logic                      pc_branch,
    output logic                      pc_disable,
    output logic                      halted,
    output logic                      fault
);

    state_t       state, state_nxt;
    instr_class_t cls;
    logic         waiting;
    logic         timeout;
    logic         in_wb;

    // instr stays stable from DECODE through WB, so one classifier serves both
    t05_opcode_classifier u_cls (
        .opcode (instr[6:0]),
        .cls    (cls)
    );

    assign waiting = (state == ST_FETCH) || (state == ST_MEM);

`ifdef CTRL_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt;

    // Counts ack-less cycles; any non-waiting state (every path into FETCH/MEM
    // passes through one) returns it to zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                          wait_cnt <= '0;
        else if (waiting && !mem.mem_ack) wait_cnt <= wait_cnt + 1'b1;
        else                              wait_cnt <= '0;
    end

    // Fires in the last allowed cycle only if that cycle has no ack either.
    assign timeout = waiting && !mem.mem_ack &&
                     (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (run) state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (mem.mem_ack)  state_nxt = ST_DECODE;
                else if (timeout) state_nxt = ST_FAULT;
            end
            ST_DECODE: begin
                case (cls)
                    CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
                    CLS_SYSTEM:          state_nxt = ST_HALT;
                    CLS_ILLEGAL:         state_nxt = ST_FAULT;
                    default:             state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem.mem_ack)  state_nxt = ST_WB;
                else if (timeout) state_nxt = ST_FAULT;
            end
            ST_WB:     state_nxt = run ? ST_FETCH : ST_IDLE;
            ST_HALT, ST_FAULT: state_nxt = state;
            default:   state_nxt = ST_FAULT;   // unused encoding
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)                                instr <= '0;
        else if (state == ST_FETCH && mem.mem_ack) instr <= mem.mem_rdata;
    end

    // Outputs decode straight from state, so clr drops mem_req without a clock.
    assign in_wb       = (state == ST_WB);
    assign mem.mem_req = waiting;
    assign mem.mem_sel = (state == ST_MEM);
    assign mem.mem_we  = (state == ST_MEM) && (cls == CLS_STORE);

    assign pc_disable  = !in_wb;
    assign pc_load     = in_wb && (cls == CLS_JALR);
    assign pc_branch   = in_wb && ((cls == CLS_JAL) || (cls == CLS_BRANCH && branch_taken));
    assign pc_inc      = in_wb && !pc_load && !pc_branch;
    assign reg_we      = in_wb && (cls != CLS_STORE) && (cls != CLS_BRANCH);

    // HALT/FAULT are terminal, which makes these flags sticky until clr.
    assign halted      = (state == ST_HALT);
    assign fault       = (state == ST_FAULT);

endmodule
